// File: rtl/jpeg2000_seq_pkg.sv
// Shared types and constants for the JPEG2000 start-pulse sequencer.
//   seq_state_t : sequencer FSM states
//   MODE_EVENT  : next pulse waits for a tile_done rise, then the gap
//   MODE_TIMED  : next pulse follows the gap alone
package jpeg2000_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT_WAIT = 3'd1,
    ST_PULSE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP_WAIT  = 3'd4,
    ST_FINISH    = 3'd5
  } seq_state_t;

  localparam logic MODE_EVENT = 1'b0;
  localparam logic MODE_TIMED = 1'b1;

endpackage

// File: rtl/jpeg2000_start_seq_edge_det.sv
// Rising-edge detector for the tile_done level coming from the core.
//   clk_dwt : clock
//   rst     : synchronous active-low reset
//   sig     : level input
//   rise    : sig high now and low on the previous cycle
module seq_edge_det (
  input  logic clk_dwt,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk_dwt) begin
    if (!rst) sig_q <= 1'b0;
    else      sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/jpeg2000_start_seq.sv
// Start-pulse sequencer driving start_cpu of jpeg2000_top.
// Issues cfg_num_starts pulses of PULSE_LEN cycles: the first after
// cfg_init_delay, later ones after a tile_done rise plus cfg_gap_delay
// (event mode) or after cfg_gap_delay alone (timed mode).
//   clk_dwt, rst        : clock, synchronous active-low reset
//   enable              : run request level; low aborts a run
//   mode                : MODE_EVENT / MODE_TIMED
//   cfg_init_delay      : cycles before the first pulse
//   cfg_gap_delay       : cycles between trigger and next pulse
//   cfg_num_starts      : pulses per run
//   tile_done           : level from core, its rise is the event
//   start_cpu           : start pulse to the core
//   busy, done          : run in progress / run complete (held until enable low)
//   start_count         : pulses issued this run
//   err_overrun         : sticky, tile_done rise outside WAIT_DONE while busy
//
// state      | meaning
// -----------+----------------------------------------------
// IDLE       | waiting for enable, config latched on exit
// INIT_WAIT  | counting down the initial delay
// PULSE      | start_cpu high for PULSE_LEN cycles
// WAIT_DONE  | event mode, waiting for a tile_done rise
// GAP_WAIT   | counting down the gap delay
// FINISH     | all pulses issued, done held until enable low
module jpeg2000_start_seq
  import jpeg2000_seq_pkg::*;
#(
  parameter int DELAY_W   = 32,
  parameter int CNT_W     = 8,
  parameter int PULSE_LEN = 2
) (
  input  logic               clk_dwt,
  input  logic               rst,
  input  logic               enable,
  input  logic               mode,
  input  logic [DELAY_W-1:0] cfg_init_delay,
  input  logic [DELAY_W-1:0] cfg_gap_delay,
  input  logic [CNT_W-1:0]   cfg_num_starts,
  input  logic               tile_done,
  output logic               start_cpu,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   start_count,
  output logic               err_overrun
);

  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  seq_state_t         state, state_nxt;
  logic [DELAY_W-1:0] dly_cnt, dly_nxt;
  logic [PW-1:0]      pulse_cnt, pcnt_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               err_nxt;
  logic               mode_q, mode_nxt;
  logic [DELAY_W-1:0] gap_q, gap_nxt;
  logic [CNT_W-1:0]   num_q, num_nxt;
  logic               td_rise;

  seq_edge_det u_edge_det (
    .clk_dwt (clk_dwt),
    .rst     (rst),
    .sig     (tile_done),
    .rise    (td_rise)
  );

  always_ff @(posedge clk_dwt) begin
    if (!rst) begin
      state       <= ST_IDLE;
      dly_cnt     <= '0;
      pulse_cnt   <= '0;
      start_count <= '0;
      err_overrun <= 1'b0;
      mode_q      <= MODE_EVENT;
      gap_q       <= '0;
      num_q       <= '0;
      start_cpu   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      dly_cnt     <= dly_nxt;
      pulse_cnt   <= pcnt_nxt;
      start_count <= cnt_nxt;
      err_overrun <= err_nxt;
      mode_q      <= mode_nxt;
      gap_q       <= gap_nxt;
      num_q       <= num_nxt;
      // outputs follow the state being entered so they are registered
      // yet line up with the state itself
      start_cpu   <= (state_nxt == ST_PULSE);
      busy        <= (state_nxt inside {ST_INIT_WAIT, ST_PULSE, ST_WAIT_DONE, ST_GAP_WAIT});
      done        <= (state_nxt == ST_FINISH);
    end
  end

  always_comb begin
    state_nxt = state;
    dly_nxt   = dly_cnt;
    pcnt_nxt  = pulse_cnt;
    cnt_nxt   = start_count;
    err_nxt   = err_overrun;
    mode_nxt  = mode_q;
    gap_nxt   = gap_q;
    num_nxt   = num_q;

    unique case (state)
      ST_IDLE: begin
        if (enable) begin
          mode_nxt = mode;
          gap_nxt  = cfg_gap_delay;
          num_nxt  = cfg_num_starts;
          cnt_nxt  = '0;
          err_nxt  = 1'b0;
          if (cfg_num_starts == '0) begin
            state_nxt = ST_FINISH;
          end else begin
            // the init delay goes straight into the counter, no copy kept
            dly_nxt   = cfg_init_delay;
            state_nxt = ST_INIT_WAIT;
          end
        end
      end
      ST_INIT_WAIT, ST_GAP_WAIT: begin
        if (dly_cnt == '0) begin
          state_nxt = ST_PULSE;
          pcnt_nxt  = PW'(PULSE_LEN - 1);
          cnt_nxt   = start_count + CNT_W'(1);
        end else begin
          dly_nxt = dly_cnt - DELAY_W'(1);
        end
      end
      ST_PULSE: begin
        if (pulse_cnt == '0) begin
          if (start_count == num_q) begin
            state_nxt = ST_FINISH;
          end else if (mode_q == MODE_TIMED) begin
            dly_nxt   = gap_q;
            state_nxt = ST_GAP_WAIT;
          end else begin
            state_nxt = ST_WAIT_DONE;
          end
        end else begin
          pcnt_nxt = pulse_cnt - PW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (td_rise) begin
          dly_nxt   = gap_q;
          state_nxt = ST_GAP_WAIT;
        end
      end
      ST_FINISH: begin
        if (!enable) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // a completion event outside WAIT_DONE is flagged and dropped
    if (td_rise && (state inside {ST_INIT_WAIT, ST_PULSE, ST_GAP_WAIT}))
      err_nxt = 1'b1;

    // abort: counters and flags freeze, state returns to IDLE
    if (!enable && (state != ST_IDLE) && (state != ST_FINISH)) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = start_count;
    end
  end

endmodule
